// File: rtl/led_sequencer_if.sv
// Wishbone classic slave bundle carrying the led_sequencer register bus.
interface led_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  // Bus initiator side.
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  // Register block side.
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: Wishbone register block, debounced buttons,
// prescaled rotate/count pattern engine and registered LED drive.
module led_sequencer #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  led_sequencer_if.slave wbs,
  input  logic [2:0]     buttons,
  output logic [7:0]     leds
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned LED_W   = 8;
  localparam int unsigned PRE_W   = 16;
  localparam int unsigned DATA_W  = 32;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_DIRECT   = 2'd1;
  localparam logic [1:0] REG_PRESCALE = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam logic [1:0] MODE_DIRECT  = 2'd0;
  localparam logic [1:0] MODE_BUTTONS = 2'd1;
  localparam logic [1:0] MODE_ROTATE  = 2'd2;
  localparam logic [1:0] MODE_COUNT   = 2'd3;

  localparam logic [LED_W-1:0] ROTATE_SEED = 8'h01;
  localparam logic [LED_W-1:0] COUNT_SEED  = 8'h00;

  // Counter value on the last of DEBOUNCE_CYCLES differing samples.
  localparam logic [PRE_W-1:0] DB_LAST = PRE_W'(DEBOUNCE_CYCLES - 16'd1);

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  bus_state_t bus_state;
  bus_state_t bus_state_nxt;

  logic                    access_c;
  logic                    xfer_c;
  logic                    wr_c;
  logic                    rd_c;
  logic [1:0]              reg_sel_c;
  logic                    wr_ctrl_c;
  logic                    wr_direct_c;
  logic                    wr_pre_c;
  logic                    clr_event_c;
  logic [DATA_W-1:0]       rdata_c;

  logic [1:0]              mode;
  logic                    run;
  logic                    dir;
  logic [LED_W-1:0]        direct;
  logic [PRE_W-1:0]        prescale;
  logic [PRE_W-1:0]        pre_cnt;
  logic                    tick_c;
  logic [LED_W-1:0]        pattern;
  logic [LED_W-1:0]        pattern_nxt;
  logic [LED_W-1:0]        leds_src_c;
  logic                    event_flag;

  logic [NUM_BTN-1:0]              sync_q1;
  logic [NUM_BTN-1:0]              sync_q2;
  logic [NUM_BTN-1:0]              deb;
  logic [NUM_BTN-1:0]              deb_nxt;
  logic [NUM_BTN-1:0]              rise_c;
  logic [NUM_BTN-1:0][PRE_W-1:0]   db_cnt;
  logic [NUM_BTN-1:0][PRE_W-1:0]   db_cnt_nxt;

  logic unused_c;

  // Address bits below the word, upper data and lanes 2/3 carry no state.
  assign unused_c = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:16]};

  // Bus access decode against the 16-byte register window.
  assign access_c  = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                     (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel_c = wbs.wbs_adr_i[3:2];

  // Bus handshake state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus_state <= BUS_IDLE;
    end else begin
      bus_state <= bus_state_nxt;
    end
  end

  // Accept in IDLE, spend exactly one cycle in ACK so transfers are spaced.
  always_comb begin
    bus_state_nxt = bus_state;
    xfer_c        = 1'b0;
    case (bus_state)
      BUS_IDLE: begin
        if (access_c) begin
          xfer_c        = 1'b1;
          bus_state_nxt = BUS_ACK;
        end
      end
      BUS_ACK: begin
        bus_state_nxt = BUS_IDLE;
      end
      default: begin
        bus_state_nxt = BUS_IDLE;
      end
    endcase
  end

  assign wbs.wbs_ack_o = (bus_state == BUS_ACK);

  // Per-register write strobes, all committed on the edge that raises ack.
  assign wr_c        = xfer_c & wbs.wbs_we_i;
  assign rd_c        = xfer_c & ~wbs.wbs_we_i;
  assign wr_ctrl_c   = wr_c & (reg_sel_c == REG_CTRL) & wbs.wbs_sel_i[0];
  assign wr_direct_c = wr_c & (reg_sel_c == REG_DIRECT) & wbs.wbs_sel_i[0];
  assign wr_pre_c    = wr_c & (reg_sel_c == REG_PRESCALE);
  assign clr_event_c = wr_c & (reg_sel_c == REG_STATUS) & wbs.wbs_sel_i[1] &
                       wbs.wbs_dat_i[11];

  // Read data mux over the current register contents.
  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      REG_CTRL:     rdata_c = DATA_W'({dir, run, mode});
      REG_DIRECT:   rdata_c = DATA_W'(direct);
      REG_PRESCALE: rdata_c = DATA_W'(prescale);
      REG_STATUS:   rdata_c = DATA_W'({event_flag, leds, deb});
      default:      rdata_c = '0;
    endcase
  end

  // Read data is only non-zero during the ack cycle of a read.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs.wbs_dat_o <= '0;
    end else if (rd_c) begin
      wbs.wbs_dat_o <= rdata_c;
    end else begin
      wbs.wbs_dat_o <= '0;
    end
  end

  // Two-flop synchronizer for the raw pad inputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= buttons;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: count consecutive differing samples, flip on the last one.
  always_comb begin
    deb_nxt    = deb;
    rise_c     = '0;
    db_cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (sync_q2[i] != deb[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          deb_nxt[i] = sync_q2[i];
          rise_c[i]  = sync_q2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Debounced button state and counters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      deb    <= '0;
      db_cnt <= '0;
    end else begin
      deb    <= deb_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Tick when the count reaches PRESCALE.
  assign tick_c = (pre_cnt == prescale);

  // Prescale counter; a PRESCALE write restarts the period.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pre_cnt <= '0;
    end else if (wr_pre_c || tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // CTRL: bus write beats the button toggles landing on the same edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mode <= MODE_DIRECT;
      run  <= 1'b0;
      dir  <= 1'b0;
    end else if (wr_ctrl_c) begin
      mode <= wbs.wbs_dat_i[1:0];
      run  <= wbs.wbs_dat_i[2];
      dir  <= wbs.wbs_dat_i[3];
    end else begin
      run  <= run ^ rise_c[0];
      dir  <= dir ^ rise_c[1];
    end
  end

  // DIRECT and PRESCALE registers with byte-lane writes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      direct   <= '0;
      prescale <= '0;
    end else begin
      if (wr_direct_c) begin
        direct <= wbs.wbs_dat_i[7:0];
      end
      if (wr_pre_c && wbs.wbs_sel_i[0]) begin
        prescale[7:0] <= wbs.wbs_dat_i[7:0];
      end
      if (wr_pre_c && wbs.wbs_sel_i[1]) begin
        prescale[15:8] <= wbs.wbs_dat_i[15:8];
      end
    end
  end

  // Pattern engine: a button2 reload beats a coincident tick.
  always_comb begin
    pattern_nxt = pattern;
    if (mode == MODE_ROTATE) begin
      if (rise_c[2]) begin
        pattern_nxt = ROTATE_SEED;
      end else if (tick_c && run) begin
        pattern_nxt = dir ? {pattern[0], pattern[7:1]} : {pattern[6:0], pattern[7]};
      end
    end else if (mode == MODE_COUNT) begin
      if (rise_c[2]) begin
        pattern_nxt = COUNT_SEED;
      end else if (tick_c && run) begin
        pattern_nxt = dir ? pattern - 8'd1 : pattern + 8'd1;
      end
    end
  end

  // Pattern register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pattern <= ROTATE_SEED;
    end else begin
      pattern <= pattern_nxt;
    end
  end

  // Sticky event: a new press outranks a same-edge clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      event_flag <= 1'b0;
    end else if (|rise_c) begin
      event_flag <= 1'b1;
    end else if (clr_event_c) begin
      event_flag <= 1'b0;
    end
  end

  // LED source selection by mode.
  always_comb begin
    leds_src_c = '0;
    case (mode)
      MODE_DIRECT:  leds_src_c = direct;
      MODE_BUTTONS: leds_src_c = LED_W'(deb);
      MODE_ROTATE:  leds_src_c = pattern;
      MODE_COUNT:   leds_src_c = pattern;
      default:      leds_src_c = '0;
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      leds <= '0;
    end else begin
      leds <= leds_src_c;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: behavioural model plus directed
// literal checks and a randomized bus/button phase.
module tb_led_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          DB   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] buttons = 3'b000;
  logic [7:0] leds;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  led_sequencer_if bus();

  led_sequencer #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs(bus),
    .buttons(buttons),
    .leds(leds)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [1:0]  m_mode;
  logic        m_run, m_dir, m_evt, m_ack;
  logic [7:0]  m_direct, m_pat, m_leds;
  logic [15:0] m_pre;
  int          m_phase;
  logic [31:0] m_dat;
  logic [2:0]  m_deb, m_raw_new, m_raw_old;
  logic [DB-1:0] m_hist [3];

  function automatic logic [31:0] m_read(input logic [1:0] r);
    case (r)
      2'd0:    return {28'd0, m_dir, m_run, m_mode};
      2'd1:    return {24'd0, m_direct};
      2'd2:    return {16'd0, m_pre};
      default: return {20'd0, m_evt, m_leds, m_deb};
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_run = 1'b0; m_dir = 1'b0; m_evt = 1'b0; m_ack = 1'b0;
    m_direct = 8'h00; m_pat = 8'h01; m_leds = 8'h00; m_pre = 16'd0;
    m_phase = 0; m_dat = 32'd0; m_deb = 3'b000; m_raw_new = 3'b000; m_raw_old = 3'b000;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
  endtask

  task automatic model_step();
    logic access, xfer, wr, rd, tick;
    logic [1:0] r;
    logic [31:0] d;
    logic [3:0] s;
    logic [2:0] sync, deb_n, rise;
    logic [7:0] pat_n, leds_n;
    int p;
    access = bus.wbs_stb_i && bus.wbs_cyc_i && (bus.wbs_adr_i[31:4] == BASE[31:4]);
    xfer = access && !m_ack;
    wr = xfer && bus.wbs_we_i;
    rd = xfer && !bus.wbs_we_i;
    r = bus.wbs_adr_i[3:2];
    d = bus.wbs_dat_i;
    s = bus.wbs_sel_i;
    // button seen by the debouncer is the pad value from two edges back
    sync = m_raw_old;
    m_raw_old = m_raw_new;
    m_raw_new = buttons;
    deb_n = m_deb;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], sync[i]};
      if (m_hist[i] == {DB{~m_deb[i]}}) deb_n[i] = ~m_deb[i];
    end
    rise = deb_n & ~m_deb;
    tick = (m_phase == int'(m_pre));
    case (m_mode)
      2'd0:    leds_n = m_direct;
      2'd1:    leds_n = {5'd0, m_deb};
      default: leds_n = m_pat;
    endcase
    p = int'(m_pat);
    pat_n = m_pat;
    if (m_mode >= 2'd2) begin
      if (rise[2]) pat_n = (m_mode == 2'd2) ? 8'h01 : 8'h00;
      else if (tick && m_run) begin
        if (m_mode == 2'd2) pat_n = m_dir ? 8'(p / 2 + (p % 2) * 128) : 8'((p * 2) % 256 + p / 128);
        else                pat_n = 8'((p + (m_dir ? 255 : 1)) % 256);
      end
    end
    m_dat = rd ? m_read(r) : 32'd0;
    if (wr && r == 2'd0 && s[0]) {m_dir, m_run, m_mode} = d[3:0];
    else begin
      m_run = m_run ^ rise[0];
      m_dir = m_dir ^ rise[1];
    end
    if (wr && r == 2'd1 && s[0]) m_direct = d[7:0];
    m_phase = (wr && r == 2'd2) ? 0 : (tick ? 0 : m_phase + 1);
    if (wr && r == 2'd2 && s[0]) m_pre[7:0] = d[7:0];
    if (wr && r == 2'd2 && s[1]) m_pre[15:8] = d[15:8];
    if (|rise) m_evt = 1'b1;
    else if (wr && r == 2'd3 && s[1] && d[11]) m_evt = 1'b0;
    m_deb = deb_n;
    m_pat = pat_n;
    m_leds = leds_n;
    m_ack = xfer;
  endtask

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle compare against the model on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
      chk("dat_o", bus.wbs_dat_o, m_dat);
      chk("leds", 32'(leds), 32'(m_leds));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = wd; bus.wbs_sel_i = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbs_ack_o && n < 8);
    chk("ack_seen", 32'(bus.wbs_ack_o), 32'd1);
    rd = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, BASE | {28'd0, r, 2'b00}, wd, sel, dummy);
  endtask

  task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
    wb_xfer(1'b0, BASE | {28'd0, r, 2'b00}, 32'd0, 4'hF, rd);
  endtask

  task automatic wait_leds(input logic [7:0] v, input int lim);
    int n;
    n = 0;
    while (leds !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_leds", 32'(leds), 32'(v));
  endtask

  task automatic next_leds(output logic [7:0] nv);
    logic [7:0] v0;
    int n;
    v0 = leds;
    n = 0;
    while (leds === v0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    nv = leds;
  endtask

  task automatic press(input logic [2:0] b);
    buttons = b;
    hold(8);
    buttons = 3'b000;
    hold(8);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [7:0]  nv;
    int n;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    rst = 1'b0;
    hold(2);

    // direct mode and STATUS readback
    wb_write(2'd1, 32'h0000_00A5, 4'hF);
    wb_write(2'd0, 32'h0, 4'hF);
    hold(2);
    chk("direct_leds", 32'(leds), 32'hA5);
    wb_read(2'd3, rd);
    chk("status_leds", 32'(rd[10:3]), 32'hA5);

    // button mode, hold all three then a short glitch on button1
    wb_write(2'd0, 32'h1, 4'h1);
    buttons = 3'b111;
    hold(10);
    chk("btn_leds", 32'(leds), 32'h07);
    buttons = 3'b101;
    hold(2);
    buttons = 3'b111;
    hold(8);
    chk("glitch_leds", 32'(leds), 32'h07);
    buttons = 3'b000;
    hold(10);
    chk("btn_release", 32'(leds), 32'h00);

    // event flag and its clear; byte lane miss on DIRECT
    wb_read(2'd3, rd);
    chk("event_set", 32'(rd[11]), 32'd1);
    wb_write(2'd3, 32'h0000_0800, 4'b0010);
    wb_read(2'd3, rd);
    chk("event_clr", 32'(rd[11]), 32'd0);
    wb_write(2'd1, 32'h0000_3C00, 4'b0010);
    wb_read(2'd1, rd);
    chk("direct_lane", rd, 32'hA5);

    // button0 toggles run (CTRL was mode1 with run/dir toggled on)
    wb_read(2'd0, rd);
    chk("ctrl_before", rd, 32'hD);
    press(3'b001);
    wb_read(2'd0, rd);
    chk("ctrl_after", rd, 32'h9);
    wb_read(2'd3, rd);
    chk("event_btn0", 32'(rd[11]), 32'd1);

    // rotate mode, one step every 4 cycles
    wb_write(2'd2, 32'd3, 4'h3);
    wb_write(2'd0, 32'h6, 4'h1);
    wait_leds(8'h02, 40);
    n = 0;
    while (leds !== 8'h04 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rot_period", 32'(n), 32'd4);
    wait_leds(8'h80, 60);
    next_leds(nv);
    chk("rot_wrap", 32'(nv), 32'h01);
    press(3'b010);
    wait_leds(8'h10, 60);
    next_leds(nv);
    chk("rot_reverse", 32'(nv), 32'h08);

    // count mode down, reload to 00 then wrap to FF
    wb_write(2'd0, 32'hF, 4'h1);
    buttons = 3'b100;
    wait_leds(8'h00, 30);
    next_leds(nv);
    chk("cnt_wrap", 32'(nv), 32'hFF);
    buttons = 3'b000;
    hold(10);
    // reload coinciding with a tick (tick every cycle)
    wb_write(2'd2, 32'd0, 4'h3);
    buttons = 3'b100;
    wait_leds(8'h00, 20);
    next_leds(nv);
    chk("cnt_reload_tick", 32'(nv), 32'hFF);
    buttons = 3'b000;
    hold(10);

    // reset in the middle of a write while rotating
    wb_write(2'd2, 32'd1, 4'h3);
    wb_write(2'd0, 32'h6, 4'h1);
    hold(5);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE | 32'h4; bus.wbs_dat_i = 32'h55; bus.wbs_sel_i = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_leds", 32'(leds), 32'h0);
    chk("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("mid_rst_dat", bus.wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    hold(1);
    wb_read(2'd1, rd);
    chk("write_dropped", rd, 32'h0);
    wb_write(2'd0, 32'h2, 4'h1);
    hold(2);
    chk("pattern_after_rst", 32'(leds), 32'h01);

    // randomized bus traffic and button activity, checked by the model
    for (int it = 0; it < 600; it++) begin
      int op;
      logic [1:0] r;
      logic [31:0] wd;
      op = $urandom_range(0, 9);
      r = 2'($urandom_range(0, 3));
      case (r)
        2'd0:    wd = 32'($urandom_range(0, 15));
        2'd2:    wd = 32'($urandom_range(0, 6));
        default: wd = $urandom & 32'h0000_0FFF;
      endcase
      if (op <= 3) begin
        wb_write(r, wd, 4'($urandom));
      end else if (op <= 5) begin
        wb_read(r, rd);
      end else if (op == 6) begin
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = 32'h4000_0000 | {28'd0, r, 2'b00};
        bus.wbs_dat_i = wd; bus.wbs_sel_i = 4'hF;
        hold(3);
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      end else if (op == 7) begin
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'($urandom);
        bus.wbs_adr_i = BASE | {28'd0, r, 2'b00};
        bus.wbs_dat_i = wd; bus.wbs_sel_i = 4'($urandom);
        hold(5);
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      end else begin
        buttons = 3'($urandom);
        hold($urandom_range(1, 12));
      end
    end
    buttons = 3'b000;
    hold(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the register block.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16'd1000, stable-input cycles needed to accept a button change (minimum 1).
REQ-003 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 wbs_sel_i  input  4  byte-lane selects; wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data.
REQ-007 wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-008 buttons  input  3  raw asynchronous pad inputs, active-high.
REQ-009 leds  output  8  registered LED drive.

Function
REQ-010 Registers at BASE_ADDR plus: 0x0 CTRL {[1:0] mode, [2] run, [3] dir}; 0x4 DIRECT [7:0]; 0x8 PRESCALE [15:0]; 0xC STATUS (RO) {[2:0] debounced buttons, [10:3] leds, [11] event}; other bits read 0.
REQ-011 Access = stb&cyc with adr[31:4]==BASE_ADDR[31:4]; wbs_ack_o asserts the cycle after an access is seen, stays high one cycle, and cannot re-assert the following cycle (one transfer per 2 cycles minimum).
REQ-012 Writes take effect on the ack edge, per byte lane via wbs_sel_i; reads present data with ack; wbs_dat_o is 0 when ack is low.
REQ-013 Writing STATUS with bit 11 = 1 clears event; other STATUS bits ignore writes.
REQ-014 Each button passes a 2-flop synchronizer, then a per-button counter: debounced value flips only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any equal cycle clears the counter.
REQ-015 Debounced rising edge of button0 toggles run; button1 toggles dir; button2 reloads pattern (8'h01 in mode 2, 8'h00 in mode 3, no effect in modes 0/1); any debounced rising edge sets event.
REQ-016 Prescaler counts 0..PRESCALE, emits a one-cycle tick on reaching PRESCALE, then returns to 0; PRESCALE=0 gives a tick every cycle; a PRESCALE write resets the count to 0.
REQ-017 Mode 2 (rotate): on tick with run=1, pattern rotates left (dir=0) or right (dir=1) by one bit.
REQ-018 Mode 3 (count): on tick with run=1, pattern increments (dir=0) or decrements (dir=1) modulo 256 (8'hFF->8'h00, 8'h00->8'hFF).
REQ-019 Pattern holds when run=0, in modes 0/1, and across mode changes.
REQ-020 leds registered one cycle after source: mode 0 DIRECT, mode 1 {5'b0, debounced buttons}, modes 2/3 pattern.
REQ-021 Same-cycle button2 reload and tick: reload wins. Same-cycle CTRL write and button0/1 toggle: Wishbone write wins. Same-cycle event set and clear: set wins.

Reset
REQ-022 On wb_rst_i: CTRL=0 (mode 0, run 0, dir 0), DIRECT=0, PRESCALE=0, pattern=8'h01, event=0, debounced buttons=0, synchronizers/counters=0, leds=0, wbs_ack_o=0, wbs_dat_o=0, immediately and asynchronously.
REQ-023 Reset asserted mid-transfer drops ack without completing the write; the transfer is not retried.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Write DIRECT=8'hA5, CTRL=0 -> leds=8'hA5; read STATUS -> [10:3]=8'hA5; ack exactly one cycle per access.
REQ-025 Mode 1, buttons=3'b111 held 10 cycles -> leds=8'h07; 2-cycle glitch on button1 -> leds unchanged.
REQ-026 Mode 2, PRESCALE=3, run=1 -> leds 01,02,04,... every 4 cycles, 8'h80->8'h01 wrap; button1 press -> direction reverses.
REQ-027 Mode 3, dir=1, pattern reloaded to 00 via button2 -> next tick leds=8'hFF; button2 coincident with tick -> leds=8'h00.
REQ-028 Button0 press -> STATUS event=1, run toggled; write STATUS 32'h800 -> event=0; byte write sel=4'b0010 to DIRECT -> DIRECT unchanged.
REQ-029 Assert wb_rst_i while running in mode 2 during a write -> all outputs 0 immediately, write discarded, pattern 8'h01 after release.
